param_circular_q: RTL

PARAM_CIRCULAR_Q -- requirements
Module: param_circular_q

---
 rtl/param_circular_q.sv | 94 +++++++++
 1 files changed

// File: rtl/param_circular_q.sv
// rtl/param_circular_q.sv - parameterised circular FIFO with show-ahead peek, registered output and bypass
module param_circular_q #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       enq,
    input  logic [WIDTH-1:0]           in,
    input  logic                       deq,
    output logic [WIDTH-1:0]           out,
    output logic                       ready,
    output logic [WIDTH-1:0]           peek,
    output logic                       peek_valid,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

    logic [WIDTH-1:0] arr [DEPTH];
    logic [AW-1:0]    front;
    logic [AW-1:0]    rear;

    logic deq_ok;
    logic enq_ok;
    logic bypass;
    logic ovf_set;
    logic unf_set;

    assign empty       = (count == '0);
    assign full        = (count == FULL_C);
    assign almost_full = (count >= AFULL_C);
    assign peek_valid  = ~empty;
    assign peek        = arr[front];

    // Bypass only exists on an empty queue, where it must not touch pointers or count.
    assign bypass  = empty & enq & deq & ~flush;
    assign deq_ok  = deq & ~empty & ~flush;
    assign enq_ok  = enq & ~flush & ~bypass & (~full | deq_ok);
    assign ovf_set = enq & ~flush & full & ~deq_ok;
    assign unf_set = deq & ~flush & empty & ~enq;

    always_ff @(posedge clk) begin
        if (enq_ok) begin
            arr[rear] <= in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            front     <= '0;
            rear      <= '0;
            count     <= '0;
            out       <= '0;
            ready     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            front     <= '0;
            rear      <= '0;
            count     <= '0;
            ready     <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            ready     <= deq_ok | bypass;
            overflow  <= ovf_set;
            underflow <= unf_set;
            if (deq_ok) begin
                out   <= arr[front];
                front <= front + 1'b1;
            end else if (bypass) begin
                out <= in;
            end
            if (enq_ok) begin
                rear <= rear + 1'b1;
            end
            case ({enq_ok, deq_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
